// File: rtl/id_imm_pipe.sv
// Decode-stage immediate generator and PC-target adder behind a two-entry
// elastic buffer (main + skid) so that in_ready comes straight from a flop.
module id_imm_pipe #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:7]     instr,
  input  logic [2:0]      ImmSrc,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ImmExt,
  output logic [XLEN-1:0] PCTarget,
  output logic            out_illegal
);

  typedef enum logic [2:0] {
    IMM_I     = 3'b000,
    IMM_S     = 3'b001,
    IMM_B     = 3'b010,
    IMM_J     = 3'b011,
    IMM_U     = 3'b100,
    IMM_SHAMT = 3'b101,
    IMM_ZIMM  = 3'b110,
    IMM_ILL   = 3'b111
  } imm_sel_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] tgt;
    logic            ill;
  } entry_t;

  imm_sel_e w_sel;
  logic [XLEN-1:0] w_imm;
  entry_t w_in;

  entry_t r_m;
  entry_t r_s;
  logic   r_m_valid;
  logic   r_s_valid;
  logic   r_in_ready;

  entry_t w_m_nxt;
  entry_t w_s_nxt;
  logic   w_m_valid_nxt;
  logic   w_s_valid_nxt;
  logic   w_accept;
  logic   w_drain;

  assign w_sel = imm_sel_e'(ImmSrc);

  // Sign formats start from an all-sign word and overwrite the low field.
  always_comb begin
    w_imm = '0;
    unique case (w_sel)
      IMM_I: begin
        w_imm       = {XLEN{instr[31]}};
        w_imm[11:0] = instr[31:20];
      end
      IMM_S: begin
        w_imm       = {XLEN{instr[31]}};
        w_imm[11:0] = {instr[31:25], instr[11:7]};
      end
      IMM_B: begin
        w_imm       = {XLEN{instr[31]}};
        w_imm[12:0] = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      IMM_J: begin
        w_imm       = {XLEN{instr[31]}};
        w_imm[20:0] = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      IMM_U: begin
        w_imm       = {XLEN{instr[31]}};
        w_imm[31:0] = {instr[31:12], 12'b0};
      end
      IMM_SHAMT: begin
        if (XLEN == 64) w_imm[5:0] = instr[25:20];
        else            w_imm[4:0] = instr[24:20];
      end
      IMM_ZIMM: w_imm[4:0] = instr[19:15];
      IMM_ILL:  w_imm = '0;
      default:  w_imm = '0;
    endcase
  end

  always_comb begin
    w_in.imm = w_imm;
    w_in.tgt = pc + w_imm;
    w_in.ill = (w_sel == IMM_ILL);
  end

  assign w_accept = in_valid & r_in_ready;
  assign w_drain  = r_m_valid & out_ready;

  // S is only writable while empty (in_ready=1), so an accept never
  // collides with S moving into M.
  always_comb begin
    w_m_nxt       = r_m;
    w_s_nxt       = r_s;
    w_m_valid_nxt = r_m_valid;
    w_s_valid_nxt = r_s_valid;
    if (flush) begin
      w_m_valid_nxt = 1'b0;
      w_s_valid_nxt = 1'b0;
    end else if (!r_m_valid || w_drain) begin
      if (r_s_valid) begin
        w_m_nxt       = r_s;
        w_m_valid_nxt = 1'b1;
        w_s_valid_nxt = 1'b0;
      end else begin
        w_m_valid_nxt = w_accept;
        if (w_accept) w_m_nxt = w_in;
      end
    end else if (w_accept) begin
      w_s_nxt       = w_in;
      w_s_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_m        <= '0;
      r_s        <= '0;
      r_m_valid  <= 1'b0;
      r_s_valid  <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      r_m        <= w_m_nxt;
      r_s        <= w_s_nxt;
      r_m_valid  <= w_m_valid_nxt;
      r_s_valid  <= w_s_valid_nxt;
      r_in_ready <= ~w_s_valid_nxt;
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_m_valid;
  assign ImmExt      = r_m.imm;
  assign PCTarget    = r_m.tgt;
  assign out_illegal = r_m.ill;

endmodule
